iterative_shift_ctrl: RTL and testbench



---
 rtl/shift_pkg.sv | 23 ++
 rtl/shift_step_unit.sv | 26 ++
 rtl/iterative_shift_ctrl.sv | 108 ++++++++++
 tb/tb_iterative_shift_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift unit.
//   - op encodings (sll/srl/sra/rol) as carried on the 2-bit op field
//   - controller state encoding
//   - default datapath width and shift-amount width
package shift_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SHAMT_W = 5;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step_unit.sv
// Combinational single-bit shift step.
//   w_in  : current working value
//   op    : selected operation (sll/srl/sra/rol)
//   w_out : working value after one bit of the selected shift
module shift_step_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] w_in,
  input  op_e              op,
  output logic [WIDTH-1:0] w_out
);

  always_comb begin
    w_out = w_in;
    case (op)
      OP_SLL:  w_out = {w_in[WIDTH-2:0], 1'b0};
      OP_SRL:  w_out = {1'b0, w_in[WIDTH-1:1]};
      OP_SRA:  w_out = {w_in[WIDTH-1], w_in[WIDTH-1:1]};
      OP_ROL:  w_out = {w_in[WIDTH-2:0], w_in[WIDTH-1]};
      default: w_out = w_in;
    endcase
  end

endmodule

// File: rtl/iterative_shift_ctrl.sv
// Multi-cycle shift controller: accepts one request (data, amount, op),
// shifts one bit per clock, then offers the result until consumed.
//   clock, reset_n        : clock and synchronous active-low reset
//   in_valid / in_ready   : request handshake (data_in, shamt, op)
//   out_valid / out_ready : result handshake (result)
//   busy                  : high while a request is in flight (SHIFT/DONE)
// All outputs come straight from flops; nothing on in_* or out_ready
// reaches an output combinationally.
module iterative_shift_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               busy
);

  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  op_e                op_q, op_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   step_w;

  shift_step_unit #(
    .WIDTH(WIDTH)
  ) u_step (
    .w_in (work_q),
    .op   (op_q),
    .w_out(step_w)
  );

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d  = data_in;
          cnt_d   = shamt;
          op_d    = op_e'(op);
          state_d = (shamt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        work_d = step_w;
        cnt_d  = cnt_q - CNT_ONE;
        // The step applied with one remaining is the last one.
        if (cnt_q == CNT_ONE) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are precomputed from the next state so they can be registered.
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
    result_d    = out_valid_d ? work_d : '0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      work_q      <= '0;
      cnt_q       <= '0;
      op_q        <= OP_SLL;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      result_q    <= result_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = result_q;

endmodule

// File: tb/tb_iterative_shift_ctrl.sv
module tb_iterative_shift_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int n_chk = 0;
  int n_bad = 0;

  iterative_shift_ctrl #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_in  (data_in),
    .shamt    (shamt),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Counts negedges after the accept edge until out_valid is seen; the
  // count k means out_valid is sampled high at accept edge + k.
  task automatic wait_valid(output int cycles);
    cycles = 0;
    do begin
      @(negedge clock);
      cycles++;
    end while (!out_valid && cycles < 40);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_result"},    result,         32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  // One request with out_ready held high; checks latency, result and
  // return to idle after the result handshake.
  task automatic do_req(input string tag, input logic [31:0] d, input logic [4:0] s,
                        input logic [1:0] o, input logic [31:0] exp_res);
    int cyc;
    @(negedge clock);
    in_valid  = 1'b1;
    data_in   = d;
    shamt     = s;
    op        = o;
    out_ready = 1'b1;
    @(posedge clock);            // accept edge T
    #1;
    in_valid = 1'b0;
    data_in  = 32'h5A5A_A5A5;    // later changes must not matter
    shamt    = 5'd7;
    op       = ~o;
    wait_valid(cyc);
    chk({tag, "_lat"},    32'(cyc),      32'(s) + 32'd1);
    chk({tag, "_res"},    result,        exp_res);
    chk({tag, "_busy"},   32'(busy),     32'd1);
    chk({tag, "_nordy"},  32'(in_ready), 32'd0);
    @(negedge clock);            // after handshake edge D
    check_idle({tag, "_post"});
  endtask

  initial begin
    int cyc;
    int stale;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    data_in   = '0;
    shamt     = '0;
    op        = 2'b00;
    out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check_idle("reset");

    do_req("sll31",   32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000);
    do_req("sra4",    32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000);
    do_req("srl4",    32'h8000_0000, 5'd4,  2'b01, 32'h0800_0000);
    do_req("rol1",    32'h8000_0001, 5'd1,  2'b11, 32'h0000_0003);
    do_req("sra0",    32'hDEAD_BEEF, 5'd0,  2'b10, 32'hDEAD_BEEF);
    do_req("rol8",    32'h1234_5678, 5'd8,  2'b11, 32'h3456_7812);
    do_req("sra_pos", 32'h7000_0000, 5'd3,  2'b10, 32'h0E00_0000);
    do_req("srl31",   32'hFFFF_FFFF, 5'd31, 2'b01, 32'h0000_0001);

    // Backpressure: result held, new request kept waiting until handshake.
    @(negedge clock);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_in   = 32'h0000_0001;
    shamt     = 5'd3;
    op        = 2'b00;
    @(posedge clock);
    #1;
    data_in = 32'hAAAA_0000;
    shamt   = 5'd2;
    op      = 2'b01;
    wait_valid(cyc);
    chk("bp_lat", 32'(cyc), 32'd4);
    chk("bp_res", result, 32'h0000_0008);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("bp_hold_res",   result,          32'h0000_0008);
      chk("bp_hold_rdy",   32'(in_ready),   32'd0);
      chk("bp_hold_valid", 32'(out_valid),  32'd1);
    end
    out_ready = 1'b1;            // handshake at the next edge D
    @(negedge clock);
    chk("bp_idle_rdy",   32'(in_ready),  32'd1);
    chk("bp_idle_valid", 32'(out_valid), 32'd0);
    @(posedge clock);            // queued request accepted at D+1
    #1 in_valid = 1'b0;
    wait_valid(cyc);
    chk("bp2_lat", 32'(cyc), 32'd3);
    chk("bp2_res", result,   32'h2AAA_8000);
    @(negedge clock);
    check_idle("bp2_post");

    // Reset in the middle of a long shift.
    @(negedge clock);
    in_valid = 1'b1;
    data_in  = 32'h0000_0001;
    shamt    = 5'd20;
    op       = 2'b00;
    @(posedge clock);            // T
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clock); // T+2
    #1 reset_n = 1'b0;
    @(posedge clock);            // T+3 sees reset
    #1 reset_n = 1'b1;
    @(negedge clock);
    check_idle("rst_mid");
    stale = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (out_valid || result != 32'd0) stale++;
    end
    chk("rst_no_stale", 32'(stale), 32'd0);

    // Nothing is lost after a reset: the next request works normally.
    do_req("after_rst", 32'h0000_00F0, 5'd4, 2'b01, 32'h0000_000F);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
